// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared constants, FSM encoding and address helper for the MEM-stage SRAM controller.
// The pipeline side is 32 bits wide; the SRAM side is a 16-bit half-word bus.
package mem_stage_sram_ctrl_pkg;

  localparam int unsigned WORD_LEN        = 32;
  localparam int unsigned SRAM_ADDR_LEN   = 18;
  localparam int unsigned SRAM_DATA_LEN   = WORD_LEN / 2;
  localparam int unsigned WORD_IDX_LEN    = SRAM_ADDR_LEN - 1;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned BASE_ADDR_DEF   = 1024;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StLo   = 2'd1;
  localparam state_t StHi   = 2'd2;
  localparam state_t StDone = 2'd3;

  // Addresses below the base wrap around the SRAM word space by design.
  function automatic logic [WORD_IDX_LEN-1:0] sram_word(input logic [WORD_LEN-1:0] byte_addr,
                                                        input logic [WORD_LEN-1:0] base);
    return WORD_IDX_LEN'((byte_addr - base) >> 2);
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// Pipeline-side request/response and SRAM-side bus signals of the MEM-stage controller.
// The slave modport is the controller's view; master is the pipeline/SRAM environment.
interface mem_stage_sram_ctrl_if;
  import mem_stage_sram_ctrl_pkg::*;

  logic                     mem_r_en;
  logic                     mem_w_en;
  logic [WORD_LEN-1:0]      addr;
  logic [WORD_LEN-1:0]      st_val;
  logic [WORD_LEN-1:0]      rd_data;
  logic                     ready;
  logic                     freeze;
  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  logic [SRAM_DATA_LEN-1:0] sram_dq_out;
  logic                     sram_dq_oe;
  logic [SRAM_DATA_LEN-1:0] sram_dq_in;
  logic                     sram_we_n;
  logic                     sram_oe_n;

  modport slave (
    input  mem_r_en, mem_w_en, addr, st_val, sram_dq_in,
    output rd_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport master (
    output mem_r_en, mem_w_en, addr, st_val, sram_dq_in,
    input  rd_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

endinterface

// File: rtl/mem_stage_sram_ctrl_sram_wait_counter.sv
// Wait-state counter for one SRAM half-word phase: counts 0..WAIT_CYCLES-1 and wraps.
// last_o flags the final cycle of a phase.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == CntW'(WAIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (en_i && last_o)) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: one 32-bit load/store as two 16-bit SRAM accesses
// with fixed wait states, freezing the pipeline while the access is in flight.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF
) (
  input logic                  clk,
  input logic                  rst,
  mem_stage_sram_ctrl_if.slave ctrl_if
);

  state_t                   state_q, state_d;
  logic                     write_q, write_d;
  logic [WORD_IDX_LEN-1:0]  word_q, word_d;
  logic [SRAM_DATA_LEN-1:0] st_hi_q, st_hi_d;
  logic [WORD_LEN-1:0]      rd_data_q, rd_data_d;
  logic [SRAM_ADDR_LEN-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DATA_LEN-1:0] sram_dq_out_q, sram_dq_out_d;

  logic req;
  logic in_phase;
  logic last;

  assign req      = ctrl_if.mem_r_en | ctrl_if.mem_w_en;
  assign in_phase = (state_q == StLo) || (state_q == StHi);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (~in_phase),
    .en_i  (in_phase),
    .last_o(last)
  );

  always_comb begin
    logic [WORD_IDX_LEN-1:0] new_word;
    new_word      = sram_word(ctrl_if.addr, WORD_LEN'(BASE_ADDR));
    state_d       = state_q;
    write_d       = write_q;
    word_d        = word_q;
    st_hi_d       = st_hi_q;
    rd_data_d     = rd_data_q;
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d       = StLo;
          // Store wins when both enables are set.
          write_d       = ctrl_if.mem_w_en;
          word_d        = new_word;
          st_hi_d       = ctrl_if.st_val[WORD_LEN-1:SRAM_DATA_LEN];
          sram_addr_d   = {new_word, 1'b0};
          sram_dq_out_d = ctrl_if.st_val[SRAM_DATA_LEN-1:0];
        end
      end
      StLo: begin
        if (last) begin
          state_d       = StHi;
          sram_addr_d   = {word_q, 1'b1};
          sram_dq_out_d = st_hi_q;
          if (!write_q) begin
            rd_data_d[SRAM_DATA_LEN-1:0] = ctrl_if.sram_dq_in;
          end
        end
      end
      StHi: begin
        if (last) begin
          state_d = StDone;
          if (!write_q) begin
            rd_data_d[WORD_LEN-1:SRAM_DATA_LEN] = ctrl_if.sram_dq_in;
          end
        end
      end
      // A request still held here belongs to the access just finished.
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      write_q       <= 1'b0;
      word_q        <= '0;
      st_hi_q       <= '0;
      rd_data_q     <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      word_q        <= word_d;
      st_hi_q       <= st_hi_d;
      rd_data_q     <= rd_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
    end
  end

  assign ctrl_if.ready       = ((state_q == StIdle) && !req) || (state_q == StDone);
  assign ctrl_if.freeze      = ~ctrl_if.ready;
  assign ctrl_if.rd_data     = rd_data_q;
  assign ctrl_if.sram_addr   = sram_addr_q;
  assign ctrl_if.sram_dq_out = sram_dq_out_q;
  assign ctrl_if.sram_dq_oe  = in_phase & write_q;
  // we_n rises on the last cycle so address and data are stable at the strobe edge.
  assign ctrl_if.sram_we_n   = ~(in_phase & write_q & ~last);
  assign ctrl_if.sram_oe_n   = ~(in_phase & ~write_q);

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Randomized scoreboard bench for mem_stage_sram_ctrl with a behavioural SRAM model
// and a word-level reference memory.
module tb_mem_stage_sram_ctrl;
  import mem_stage_sram_ctrl_pkg::*;

  localparam int unsigned W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_sram_ctrl_if bus ();

  mem_stage_sram_ctrl #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (1024)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctrl_if(bus)
  );

  // SRAM model: a write lands when a full we_n-low cycle ends without reset.
  logic [15:0] sram_mem [0:(1<<18)-1];
  always @(posedge clk) begin
    if (!bus.sram_we_n && !rst) sram_mem[bus.sram_addr] <= bus.sram_dq_out;
  end
  assign bus.sram_dq_in = bus.sram_oe_n ? 16'hFFFF : sram_mem[bus.sram_addr];

  typedef struct packed {
    logic        write;
    logic [16:0] word;
    logic [31:0] data;
    logic [31:0] rd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] ref_rd;
  int          compared;
  int          mismatched;
  bit          mon_en;

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return 17'((off / 4) % (32'd1 << 17));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: per-cycle bus checks during freeze, completion checks at ready.
  int idx = 0;
  always @(negedge clk) begin : monitor
    exp_t e;
    int   ph;
    int   pos;
    if (rst || !mon_en) begin
      idx = 0;
    end else if (bus.freeze) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_busy: freeze=1 with no access outstanding (t=%0t)", $time);
      end else begin
        e = exp_q[0];
        if (idx == 0 || idx > 2 * W) begin
          check("ctrl_idle", {61'd0, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe}, 64'b110);
        end else begin
          ph  = (idx - 1) / W;
          pos = (idx - 1) % W;
          check("ctrl_phase", {61'd0, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe},
                {61'd0, !(e.write && pos < W - 1), e.write, e.write});
          check("sram_addr", {46'd0, bus.sram_addr}, {46'd0, e.word, ph[0]});
          if (e.write) begin
            check("sram_dq_out", {48'd0, bus.sram_dq_out},
                  {48'd0, (ph == 1) ? e.data[31:16] : e.data[15:0]});
          end
        end
      end
      idx++;
    end else if (idx > 0) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("freeze_cycles", 64'(idx), 64'(2 * W + 1));
        check("done_ctrl", {61'd0, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe}, 64'b110);
        check("rd_data", {32'd0, bus.rd_data}, {32'd0, e.rd});
        if (e.write) begin
          check("sram_store", {32'd0, sram_mem[{e.word, 1'b1}], sram_mem[{e.word, 1'b0}]},
                {32'd0, e.data});
        end
      end
      idx = 0;
    end
  end

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.mem_r_en = 1'b0;
      bus.mem_w_en = 1'b0;
    end
  endtask

  task automatic issue(input bit r, input bit w, input logic [31:0] a, input logic [31:0] v,
                       input bit flush);
    exp_t e;
    int   n;
    bit   ok;
    @(posedge clk);
    #1;
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.addr     = a;
    bus.st_val   = v;
    e.write = w;
    e.word  = word_of(a);
    e.data  = v;
    if (w) begin
      ref_mem[e.word] = v;
    end else begin
      ref_rd = ref_mem.exists(e.word) ? ref_mem[e.word] : 32'd0;
    end
    e.rd = ref_rd;
    exp_q.push_back(e);
    n  = 0;
    ok = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.ready) begin
        ok = 1'b1;
        break;
      end
      if (flush && n == 1) begin
        @(posedge clk);
        #1;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: ready=0 after %0d cycles, expected 1", n);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] v;
    logic [31:0] a;
    int          op;
    for (int i = 0; i < (1 << 18); i++) sram_mem[i] = 16'h0000;
    rst          = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.addr     = '0;
    bus.st_val   = '0;
    mon_en       = 1'b0;
    ref_rd       = '0;
    compared     = 0;
    mismatched   = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd_data", {32'd0, bus.rd_data}, 64'd0);
    check("rst_sram_addr", {46'd0, bus.sram_addr}, 64'd0);
    check("rst_dq_out", {48'd0, bus.sram_dq_out}, 64'd0);
    check("rst_ctrl", {59'd0, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe, bus.ready,
                       bus.freeze}, 64'b11010);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    issue(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
    drive_idle(1);
    check("store_hw2", {48'd0, sram_mem[2]}, 64'hBEEF);
    check("store_hw3", {48'd0, sram_mem[3]}, 64'hDEAD);

    issue(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0);
    drive_idle(1);

    // Back-to-back: request held through DONE, next one issued immediately.
    issue(1'b0, 1'b1, 32'd1032, $urandom, 1'b0);
    issue(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0);
    drive_idle(2);

    issue(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
    drive_idle(1);

    // Reset in the high half of a store.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_w_en = 1'b1;
    bus.addr     = 32'd1024;
    bus.st_val   = 32'hAAAA5555;
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.mem_w_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ctrl", {59'd0, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe, bus.ready,
                         bus.freeze}, 64'b11010);
    check("abort_rd_data", {32'd0, bus.rd_data}, 64'd0);
    check("abort_hw0", {48'd0, sram_mem[0]}, 64'h5555);
    check("abort_hw1", {48'd0, sram_mem[1]}, 64'h1234);
    ref_mem[0] = 32'h12345555;
    ref_rd     = 32'd0;
    mon_en     = 1'b1;

    issue(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0);
    drive_idle(1);

    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      a  = $urandom_range(0, 2047);
      v  = $urandom;
      issue(op != 1, op != 0, a, v, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 1) drive_idle($urandom_range(1, 2));
    end

    drive_idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
